// File: rtl/dot_stream_acc.sv
// Streaming Q-format dot product: weights via master_*, activations via master2_*,
// optional bias add and SRAM write-back. Build macro RELU_EN clamps negative results to 0.
module dot_stream_acc #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [DATA_W-1:0] slave_readdata,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic              master2_waitrequest,
  output logic [31:0]       master2_address,
  output logic              master2_read,
  input  logic [DATA_W-1:0] master2_readdata,
  input  logic              master2_readdatavalid,
  output logic              master2_write,
  output logic [DATA_W-1:0] master2_writedata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, BIAS, WRITE} state_t;
  state_t state, state_nx;

  logic [31:0]              bias_addr, w_addr, a_addr, out_addr;
  logic [LEN_W-1:0]         len, cnt_reg, w_iss, a_iss, pop_cnt, w_out, a_out;
  logic                     bias_en, wb_en, bias_issued;
  logic signed [DATA_W-1:0] result, acc_p1, acc_nx, final_val;
  logic                     start, done, w_req, a_req, w_push, a_push, pop;

  logic signed [DATA_W-1:0] w_mem [FIFO_DEPTH];
  logic signed [DATA_W-1:0] a_mem [FIFO_DEPTH];
  logic [PW-1:0]            w_wp, w_rp, a_wp, a_rp;
  logic [CW-1:0]            w_cnt, a_cnt;
  logic signed [DATA_W-1:0] w_head, a_head;

  logic signed [2*DATA_W-1:0] p_p0;
  logic                       vld_p0;

  function automatic logic signed [2*DATA_W-1:0] mul_q(input logic signed [DATA_W-1:0] x,
                                                      input logic signed [DATA_W-1:0] y);
    logic signed [2*DATA_W-1:0] xe, ye;
    xe = {{DATA_W{x[DATA_W-1]}}, x};
    ye = {{DATA_W{y[DATA_W-1]}}, y};
    return xe * ye;
  endfunction

  // Truncating rescale back to Q(DATA_W-FRAC_W).FRAC_W; overflow wraps.
  function automatic logic signed [DATA_W-1:0] scale_q(input logic signed [2*DATA_W-1:0] p);
    return DATA_W'(p >>> FRAC_W);
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_q(input logic signed [DATA_W-1:0] v);
`ifdef RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign start  = (state == IDLE) && slave_write && (slave_address == 4'd0);
  assign w_out  = w_iss - pop_cnt;
  assign a_out  = a_iss - pop_cnt;
  assign w_req  = (state == STREAM) && (w_iss != len) && (w_out < LEN_W'(FIFO_DEPTH));
  assign a_req  = (state == STREAM) && (a_iss != len) && (a_out < LEN_W'(FIFO_DEPTH));
  assign w_push = (state == STREAM) && master_readdatavalid;
  assign a_push = (state == STREAM) && master2_readdatavalid;
  assign pop    = (state == STREAM) && (w_cnt != '0) && (a_cnt != '0);
  assign w_head = w_mem[w_rp];
  assign a_head = a_mem[a_rp];

  assign master_write     = 1'b0;
  assign master_writedata = '0;

  // The product in flight is folded in combinationally so the exit cycle sees the full sum.
  always_comb begin
    acc_nx = acc_p1;
    if (vld_p0)
      acc_nx = acc_p1 + scale_q(p_p0);
    else if (state == BIAS && bias_issued && master_readdatavalid)
      acc_nx = acc_p1 + $signed(master_readdata);
  end

  assign final_val = relu_q(acc_nx);

  always_comb begin
    state_nx          = state;
    done              = 1'b0;
    slave_waitrequest = (state != IDLE);
    master_read       = 1'b0;
    master_address    = '0;
    master2_read      = 1'b0;
    master2_address   = '0;
    master2_write     = 1'b0;
    master2_writedata = '0;
    case (state)
      IDLE: if (start) state_nx = STREAM;
      STREAM: begin
        master_read  = w_req;
        master2_read = a_req;
        if (w_req) master_address  = w_addr + 32'({w_iss, 2'b00});
        if (a_req) master2_address = a_addr + 32'({a_iss, 2'b00});
        if (pop_cnt == len) begin
          if (bias_en)    state_nx = BIAS;
          else if (wb_en) state_nx = WRITE;
          else begin
            state_nx = IDLE;
            done     = 1'b1;
          end
        end
      end
      BIAS: begin
        master_read = !bias_issued;
        if (!bias_issued) master_address = bias_addr;
        if (bias_issued && master_readdatavalid) begin
          if (wb_en) state_nx = WRITE;
          else begin
            state_nx = IDLE;
            done     = 1'b1;
          end
        end
      end
      WRITE: begin
        master2_write     = 1'b1;
        master2_address   = out_addr;
        master2_writedata = final_val;
        if (!master2_waitrequest) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    slave_readdata = '0;
    if (state == IDLE && slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = result;
        4'd1:    slave_readdata = DATA_W'(bias_addr);
        4'd2:    slave_readdata = DATA_W'(w_addr);
        4'd3:    slave_readdata = DATA_W'(a_addr);
        4'd4:    slave_readdata = DATA_W'(out_addr);
        4'd5:    slave_readdata = DATA_W'(len);
        4'd6:    slave_readdata = DATA_W'({wb_en, bias_en});
        4'd7:    slave_readdata = DATA_W'(cnt_reg);
        default: slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bias_addr   <= '0;
      w_addr      <= '0;
      a_addr      <= '0;
      out_addr    <= '0;
      len         <= '0;
      bias_en     <= 1'b0;
      wb_en       <= 1'b0;
      w_iss       <= '0;
      a_iss       <= '0;
      pop_cnt     <= '0;
      bias_issued <= 1'b0;
      result      <= '0;
      cnt_reg     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && slave_write) begin
        case (slave_address)
          4'd1: bias_addr <= 32'(slave_writedata);
          4'd2: w_addr    <= 32'(slave_writedata);
          4'd3: a_addr    <= 32'(slave_writedata);
          4'd4: out_addr  <= 32'(slave_writedata);
          4'd5: len       <= slave_writedata[LEN_W-1:0];
          4'd6: begin
            bias_en <= slave_writedata[0];
            wb_en   <= slave_writedata[1];
          end
          default: ;
        endcase
      end
      if (start) begin
        w_iss       <= '0;
        a_iss       <= '0;
        pop_cnt     <= '0;
        bias_issued <= 1'b0;
      end else begin
        if (w_req && !master_waitrequest)  w_iss   <= w_iss + LEN_W'(1);
        if (a_req && !master2_waitrequest) a_iss   <= a_iss + LEN_W'(1);
        if (pop)                           pop_cnt <= pop_cnt + LEN_W'(1);
        if (state == BIAS && !bias_issued && !master_waitrequest) bias_issued <= 1'b1;
      end
      if (done) begin
        result  <= final_val;
        cnt_reg <= pop_cnt;
      end
    end
  end

  // Stage p0: pop one pair into the product register; stage p1: accumulate.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      w_wp   <= '0;
      w_rp   <= '0;
      w_cnt  <= '0;
      a_wp   <= '0;
      a_rp   <= '0;
      a_cnt  <= '0;
      vld_p0 <= 1'b0;
      p_p0   <= '0;
      acc_p1 <= '0;
    end else begin
      if (w_push) w_wp <= w_wp + PW'(1);
      if (a_push) a_wp <= a_wp + PW'(1);
      if (pop) begin
        w_rp <= w_rp + PW'(1);
        a_rp <= a_rp + PW'(1);
        p_p0 <= mul_q(w_head, a_head);
      end
      w_cnt  <= w_cnt + CW'(w_push) - CW'(pop);
      a_cnt  <= a_cnt + CW'(a_push) - CW'(pop);
      vld_p0 <= pop;
      acc_p1 <= acc_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) w_mem[w_wp] <= master_readdata;
    if (a_push) a_mem[a_wp] <= master2_readdata;
  end

endmodule
